// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and counter sizing.
package serial_subtractor_pkg;

  typedef logic [0:0] state_t;

  localparam state_t IDLE = 1'b0;
  localparam state_t RUN  = 1'b1;

  // Bit-counter width; a floor of one bit keeps the counter a legal vector.
  function automatic int cnt_width(input int w);
    return (w < 32'sd2) ? 32'sd1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - bi, bo is the borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell walks A - B - bin LSB first,
// one bit per clock, with registered busy/done/diff/bout.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             cell_d_s;
  logic             cell_bo_s;

  full_subtractor u_cell (
    .x  (a_sr_q[0]),
    .y  (b_sr_q[0]),
    .bi (borrow_q),
    .d  (cell_d_s),
    .bo (cell_bo_s)
  );

  // Next-state logic for the FSM, datapath shift registers and output registers.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    bout_d   = bout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          borrow_d = bin;
          cnt_d    = {CW{1'b0}};
          busy_d   = 1'b1;
          state_d  = RUN;
        end else begin
          busy_d   = 1'b0;
        end
      end
      RUN: begin
        res_d    = {cell_d_s, res_q[WIDTH-1:1]};
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        borrow_d = cell_bo_s;
        if (cnt_q == LAST) begin
          // Final bit: publish the result in the same edge the FSM leaves RUN.
          diff_d  = res_d;
          bout_d  = cell_bo_s;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = {CW{1'b0}};
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset that aborts any operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= {CW{1'b0}};
      a_sr_q   <= {WIDTH{1'b0}};
      b_sr_q   <= {WIDTH{1'b0}};
      res_q    <= {WIDTH{1'b0}};
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= {WIDTH{1'b0}};
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial subtractor: computes A − B − bin over WIDTH bits, one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. It is the subtract-direction counterpart to the team's adder blocks and gives the arithmetic set a sequential, handshaked datapath. Intended users are small control datapaths where area matters more than latency.

## Interface
- WIDTH, 8, operand and result width in bits (≥ 2).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on a rising edge of clk.
- a  input  WIDTH  minuend; captured when start is accepted.
- b  input  WIDTH  subtrahend; captured when start is accepted.
- bin  input  1  borrow-in; captured when start is accepted.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; diff and bout are valid from this cycle onward.
- diff  output  WIDTH  result (a − b − bin) mod 2^WIDTH. Registered; holds its value until the next done.
- bout  output  1  final borrow: 1 iff a < b + bin, unsigned. Registered; holds with diff.

## Operation
- FSM states are IDLE and RUN. Reset state is IDLE.
- **IDLE**
  - If start = 1 at an edge, capture a, b and bin into the shift registers and the borrow flip-flop.
  - Clear the bit counter and go to RUN.
  - If start = 0, stay in IDLE.
- **RUN**, on each edge:
  - The cell takes x = a_sr[0], y = b_sr[0], bi = borrow_ff.
  - d = x ^ y ^ bi.
  - bo = (~x & y) | (~(x ^ y) & bi).
  - Shift d into the MSB of the result shift register. Shift a_sr and b_sr right. Set borrow_ff ← bo. Increment the counter.
  - On the edge that processes bit WIDTH−1:
    - load diff from the shifted result and bout from bo;
    - set done = 1 for the following cycle;
    - return to IDLE.
- start is ignored while busy = 1. Operands on a/b/bin are don't-care outside the accepting edge.
- Counter width is $clog2(WIDTH). It never wraps within an operation.
- Arithmetic is unsigned modulo 2^WIDTH. bout is the sole overflow indicator.
- Reset values:
  - busy = 0, done = 0, diff = 0, bout = 0;
  - FSM = IDLE, counter = 0, borrow_ff = 0, shift registers = 0.
- Reset mid-operation aborts immediately:
  - no done pulse is produced;
  - diff/bout go to 0;
  - the next start after rst deasserts begins a fresh operation.

## Timing
- start is accepted at edge k (FSM in IDLE). Then:
  - busy = 1 from edge k through edge k+WIDTH;
  - bits 0..WIDTH−1 are processed at edges k+1..k+WIDTH;
  - at edge k+WIDTH: busy → 0, done → 1, diff/bout update;
  - at edge k+WIDTH+1: done → 0.
- Latency from start to done is WIDTH+1 edges. The next operation can be accepted no sooner than edge k+WIDTH+1, with start high during the done cycle.
- Back-to-back: start held high continuously gives one operation every WIDTH+1 cycles. diff holds the previous result until the new done.
- diff, bout and done are all register outputs. There is no combinational path from inputs to outputs.

## Structure
- The shared arithmetic package holds:
  - the state enum (IDLE, RUN);
  - a localparam function for counter width.
- One sub-module, full_subtractor (x, y, bi → d, bo), is purely combinational and instantiated once.
- The top level contains the FSM, counter, three WIDTH-bit shift registers, borrow_ff and output registers. Expected size is about 150 lines.

## Test plan
- WIDTH=8; a=0x5A, b=0x23, bin=0, start pulsed at edge k:
  - busy high for edges k..k+8;
  - done at k+8 for one cycle only;
  - diff=0x37, bout=0.
- a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1. Also a=0x10, b=0x0F, bin=1 → diff=0x00, bout=0.
- Ignored start: start op (0x80−0x01); at k+3, pulse start with a=0xFF, b=0xFF:
  - the second request is ignored;
  - the result is 0x7F, bout=0;
  - exactly one done pulse occurs.
- Reset mid-op: start op; assert rst asynchronously mid-cycle at k+4:
  - busy, done, diff and bout are 0 immediately, with no done pulse;
  - after rst release, 0x09−0x04 gives diff=0x05 at the expected latency.
- Back-to-back: start held high for three ops (0x05−0x03, 0x03−0x05, 0xFF−0x00):
  - done at k+8, k+17, k+26;
  - diffs 0x02/0x00, 0xFE/1, 0xFF/0 (diff/bout);
  - diff is stable between dones.
- Randomized sweep: 1000 random a, b, bin, with and without gaps → every result matches (a−b−bin) mod 256 and bout = (a < b+bin).
